// File: rtl/spu_pkg.sv
// Shared definitions for the SPU fixed-point shift/rotate pipeline:
// instruction formats, shift kinds, lane geometry, opcodes and the stage record.
package spu_pkg;

   typedef enum logic [2:0] {
      FMT_RR  = 3'd0,
      FMT_RI7 = 3'd1
   } format_e;

   typedef enum logic [1:0] {
      SK_SHL  = 2'd0,   // shift left, zero fill
      SK_ROT  = 2'd1,   // rotate left
      SK_ROTM = 2'd2    // logical shift right by negated count
   } shift_kind_e;

   localparam int VEC_W      = 128;
   localparam int HW_W       = 16;
   localparam int WORD_W     = 32;
   localparam int HW_LANES   = VEC_W / HW_W;
   localparam int WORD_LANES = VEC_W / WORD_W;

   // RR opcodes
   localparam logic [0:10] OP_NOP   = 11'b00000000000;
   localparam logic [0:10] OP_SHLH  = 11'b00001011111;
   localparam logic [0:10] OP_SHL   = 11'b00001011011;
   localparam logic [0:10] OP_ROTH  = 11'b00001011100;
   localparam logic [0:10] OP_ROT   = 11'b00001011000;
   localparam logic [0:10] OP_ROTHM = 11'b00001011101;
   localparam logic [0:10] OP_ROTM  = 11'b00001011001;

   // RI7 opcodes
   localparam logic [0:10] OP_SHLHI = 11'b00001111111;
   localparam logic [0:10] OP_SHLI  = 11'b00001111011;
   localparam logic [0:10] OP_ROTHI = 11'b00001111100;
   localparam logic [0:10] OP_ROTI  = 11'b00001111000;

   // One staging register: result, destination, write enable, unknown-op flag.
   typedef struct packed {
      logic [0:VEC_W-1] val;
      logic [0:6]       addr;
      logic             wr;
      logic             err;
   } stage_t;

endpackage

// File: rtl/spu_shift_lane.sv
// One halfword (W=16) or word (W=32) lane of the shift/rotate unit.
// i_cnt carries the low six bits of the lane's count source; higher bits
// never influence any of the supported operations.
module spu_shift_lane
   import spu_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0]  i_a,
   input  logic [5:0]    i_cnt,
   input  shift_kind_e   i_kind,
   output logic [W-1:0]  o_res
);

   localparam int         ROT_W    = (W == 16) ? 4 : 5;
   localparam logic [5:0] CNT_MASK = (W == 16) ? 6'h1F : 6'h3F;
   localparam logic [5:0] W6       = 6'(W);

   logic [5:0]     w_shl_cnt;
   logic [5:0]     w_rotm_cnt;
   logic [ROT_W-1:0] w_rot_cnt;
   logic [2*W-1:0] w_dbl;

   // Lane datapath: masked counts, then the selected shift or rotate.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
      o_res      = '0;
      w_shl_cnt  = i_cnt & CNT_MASK;
      w_rotm_cnt = (6'd0 - i_cnt) & CNT_MASK;
      w_rot_cnt  = i_cnt[ROT_W-1:0];
      w_dbl      = {i_a, i_a} << w_rot_cnt;
      case (i_kind)
         SK_SHL:  o_res = (w_shl_cnt >= W6) ? '0 : (i_a << w_shl_cnt);
         SK_ROT:  o_res = w_dbl[2*W-1:W];
         SK_ROTM: o_res = (w_rotm_cnt >= W6) ? '0 : (i_a >> w_rotm_cnt);
         default: o_res = '0;
      endcase
   end

endmodule

// File: rtl/simple_fixed_shift.sv
// SPU fixed-point shift/rotate pipe: decodes and computes in the capture
// cycle, then carries the result through LATENCY staging registers.
// Writeback is the last stage; every stage is exposed for bypassing.
module simple_fixed_shift
   import spu_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter bit FWD_EN  = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [0:10]      op,
   input  logic [2:0]       format,
   input  logic [0:6]       rt_addr,
   input  logic [0:VEC_W-1] ra,
   input  logic [0:VEC_W-1] rb,
   input  logic [0:17]      imm,
   input  logic             reg_write,
   input  logic             flush,
   output logic [0:VEC_W-1] rt_wb,
   output logic [0:6]       rt_addr_wb,
   output logic             reg_write_wb,
   output logic             err_wb,
   output logic [0:VEC_W-1] fwd_rt   [LATENCY],
   output logic [0:6]       fwd_addr [LATENCY],
   output logic             fwd_wr   [LATENCY]
);

   format_e          w_fmt;
   shift_kind_e      w_kind;
   logic             w_word;
   logic             w_use_imm;
   logic             w_known;
   logic             w_nop;
   logic [0:VEC_W-1] w_hw_res;
   logic [0:VEC_W-1] w_word_res;
   logic [0:HW_LANES-1] w_unused_rb;
   logic             w_unused;
   stage_t           w_cap;
   stage_t           r_stage [LATENCY];

   assign w_fmt = format_e'(format);

   // Decode format/opcode into shift kind, lane width and count source.
   always_comb begin
      w_kind    = SK_SHL;
      w_word    = 1'b0;
      w_use_imm = 1'b0;
      w_known   = 1'b1;
      w_nop     = 1'b0;
      case (w_fmt)
         FMT_RR: begin
            case (op)
               OP_NOP:   w_nop = 1'b1;
               OP_SHLH:  w_kind = SK_SHL;
               OP_SHL:   begin w_kind = SK_SHL;  w_word = 1'b1; end
               OP_ROTH:  w_kind = SK_ROT;
               OP_ROT:   begin w_kind = SK_ROT;  w_word = 1'b1; end
               OP_ROTHM: w_kind = SK_ROTM;
               OP_ROTM:  begin w_kind = SK_ROTM; w_word = 1'b1; end
               default:  w_known = 1'b0;
            endcase
         end
         FMT_RI7: begin
            w_use_imm = 1'b1;
            case (op)
               OP_SHLHI: w_kind = SK_SHL;
               OP_SHLI:  begin w_kind = SK_SHL; w_word = 1'b1; end
               OP_ROTHI: w_kind = SK_ROT;
               OP_ROTI:  begin w_kind = SK_ROT; w_word = 1'b1; end
               default:  w_known = 1'b0;
            endcase
         end
         default: w_known = 1'b0;
      endcase
   end

   // Halfword lanes; count is the low six bits of the matching rb halfword.
   for (genvar i = 0; i < HW_LANES; i++) begin : g_hw
      logic [5:0] w_cnt;
      assign w_cnt = w_use_imm ? imm[12:17] : rb[i*HW_W + HW_W - 6 +: 6];
      assign w_unused_rb[i] = ^rb[i*HW_W +: HW_W - 6];
      spu_shift_lane #(.W(HW_W)) u_lane (
         .i_a    (ra[i*HW_W +: HW_W]),
         .i_cnt  (w_cnt),
         .i_kind (w_kind),
         .o_res  (w_hw_res[i*HW_W +: HW_W])
      );
   end

   // Word lanes; count is the low six bits of the matching rb word.
   for (genvar i = 0; i < WORD_LANES; i++) begin : g_word
      logic [5:0] w_cnt;
      assign w_cnt = w_use_imm ? imm[12:17] : rb[i*WORD_W + WORD_W - 6 +: 6];
      spu_shift_lane #(.W(WORD_W)) u_lane (
         .i_a    (ra[i*WORD_W +: WORD_W]),
         .i_cnt  (w_cnt),
         .i_kind (w_kind),
         .o_res  (w_word_res[i*WORD_W +: WORD_W])
      );
   end

   // Count bits above the six that matter are intentionally ignored.
   assign w_unused = ^{imm[0:11], w_unused_rb};

   // Build the record captured into stage 0: nop, unknown op, or live result.
   always_comb begin
      w_cap = '0;
      if (!w_known) begin
         w_cap.addr = rt_addr;
         w_cap.err  = 1'b1;
      end else if (!w_nop) begin
         w_cap.val  = w_word ? w_word_res : w_hw_res;
         w_cap.addr = rt_addr;
         w_cap.wr   = reg_write;
      end
   end

   // Staging pipeline: reset beats flush beats capture.
   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         // NOTE: every field of every stage is cleared, not just a valid bit, because fwd_* and err_wb expose raw stage contents.
         for (int k = 0; k < LATENCY; k++) r_stage[k] <= '0;
      end else begin
         // NOTE: non-blocking assignments make each stage take its predecessor's pre-edge value, independent of statement order.
         r_stage[0] <= w_cap;
         for (int k = 1; k < LATENCY; k++) r_stage[k] <= r_stage[k-1];
      end
   end

   assign rt_wb        = r_stage[LATENCY-1].val;
   assign rt_addr_wb   = r_stage[LATENCY-1].addr;
   assign reg_write_wb = r_stage[LATENCY-1].wr;
   assign err_wb       = r_stage[LATENCY-1].err;

   if (FWD_EN) begin : g_fwd
      for (genvar k = 0; k < LATENCY; k++) begin : g_stage
         assign fwd_rt[k]   = r_stage[k].val;
         assign fwd_addr[k] = r_stage[k].addr;
         assign fwd_wr[k]   = r_stage[k].wr;
      end
   end else begin : g_no_fwd
      for (genvar k = 0; k < LATENCY; k++) begin : g_stage
         assign fwd_rt[k]   = '0;
         assign fwd_addr[k] = '0;
         assign fwd_wr[k]   = 1'b0;
      end
   end

endmodule

// File: tb/tb_simple_fixed_shift.sv
// Self-checking bench for simple_fixed_shift: three instances (LATENCY 4, 2
// with forwarding disabled, and 8) share one stimulus stream. A timeline
// model of captured instructions predicts every output on every cycle.
module tb_simple_fixed_shift;

   typedef struct packed {
      logic [0:127] val;
      logic [0:6]   addr;
      logic         wr;
      logic         err;
   } rec_t;

   typedef struct {
      string        name;
      logic [0:10]  op;
      logic [2:0]   fmt;
      logic [0:127] ra;
      logic [0:127] rb;
      logic [0:17]  imm;
      logic [0:127] exp_val;
      logic         exp_wr;
      logic         exp_err;
   } vec_t;

   localparam int MAXC   = 4096;
   localparam int K_SHL  = 0;
   localparam int K_ROT  = 1;
   localparam int K_ROTM = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic [0:10]  op;
   logic [2:0]   format;
   logic [0:6]   rt_addr;
   logic [0:127] ra, rb;
   logic [0:17]  imm;
   logic         reg_write;
   logic         flush;

   logic [0:127] rt_wb4, rt_wb2, rt_wb8;
   logic [0:6]   rt_addr_wb4, rt_addr_wb2, rt_addr_wb8;
   logic         reg_write_wb4, reg_write_wb2, reg_write_wb8;
   logic         err_wb4, err_wb2, err_wb8;
   logic [0:127] fwd_rt4 [4];
   logic [0:6]   fwd_addr4 [4];
   logic         fwd_wr4 [4];
   logic [0:127] fwd_rt2 [2];
   logic [0:6]   fwd_addr2 [2];
   logic         fwd_wr2 [2];
   logic [0:127] fwd_rt8 [8];
   logic [0:6]   fwd_addr8 [8];
   logic         fwd_wr8 [8];

   int   n_tests = 0;
   int   n_fail  = 0;
   rec_t hist [MAXC];
   int   t = -1;
   int   last_kill = -1;

   always #5 clk = ~clk;

   simple_fixed_shift #(.LATENCY(4), .FWD_EN(1'b1)) u_dut4 (
      .clk(clk), .reset(reset), .op(op), .format(format), .rt_addr(rt_addr),
      .ra(ra), .rb(rb), .imm(imm), .reg_write(reg_write), .flush(flush),
      .rt_wb(rt_wb4), .rt_addr_wb(rt_addr_wb4), .reg_write_wb(reg_write_wb4), .err_wb(err_wb4),
      .fwd_rt(fwd_rt4), .fwd_addr(fwd_addr4), .fwd_wr(fwd_wr4));

   simple_fixed_shift #(.LATENCY(2), .FWD_EN(1'b0)) u_dut2 (
      .clk(clk), .reset(reset), .op(op), .format(format), .rt_addr(rt_addr),
      .ra(ra), .rb(rb), .imm(imm), .reg_write(reg_write), .flush(flush),
      .rt_wb(rt_wb2), .rt_addr_wb(rt_addr_wb2), .reg_write_wb(reg_write_wb2), .err_wb(err_wb2),
      .fwd_rt(fwd_rt2), .fwd_addr(fwd_addr2), .fwd_wr(fwd_wr2));

   simple_fixed_shift #(.LATENCY(8), .FWD_EN(1'b1)) u_dut8 (
      .clk(clk), .reset(reset), .op(op), .format(format), .rt_addr(rt_addr),
      .ra(ra), .rb(rb), .imm(imm), .reg_write(reg_write), .flush(flush),
      .rt_wb(rt_wb8), .rt_addr_wb(rt_addr_wb8), .reg_write_wb(reg_write_wb8), .err_wb(err_wb8),
      .fwd_rt(fwd_rt8), .fwd_addr(fwd_addr8), .fwd_wr(fwd_wr8));

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got %h, expected %h", name, t, act, exp);
      end
   endtask

   // Operation table straight from the opcode list: kind and lane width.
   function automatic void op_info(input logic [2:0] f, input logic [0:10] o,
                                   output int kind, output int w);
      kind = -1;
      w    = 0;
      if (f == 3'd0) begin
         case (o)
            11'b00001011111: begin kind = K_SHL;  w = 16; end
            11'b00001011011: begin kind = K_SHL;  w = 32; end
            11'b00001011100: begin kind = K_ROT;  w = 16; end
            11'b00001011000: begin kind = K_ROT;  w = 32; end
            11'b00001011101: begin kind = K_ROTM; w = 16; end
            11'b00001011001: begin kind = K_ROTM; w = 32; end
            default: ;
         endcase
      end else if (f == 3'd1) begin
         case (o)
            11'b00001111111: begin kind = K_SHL; w = 16; end
            11'b00001111011: begin kind = K_SHL; w = 32; end
            11'b00001111100: begin kind = K_ROT; w = 16; end
            11'b00001111000: begin kind = K_ROT; w = 32; end
            default: ;
         endcase
      end
   endfunction

   // One lane in plain arithmetic: shl masks count mod 2w, rot mod w, rotm negates.
   function automatic logic [31:0] ref_lane(input int kind, input int w,
                                            input logic [31:0] v, input logic [31:0] c);
      longint unsigned val, cnt, wmask, res;
      longint unsigned n;
      val   = 64'(v);
      cnt   = 64'(c);
      wmask = (64'd1 << w) - 64'd1;
      res   = 0;
      case (kind)
         K_SHL: begin
            n   = cnt % longint'(2 * w);
            res = (n >= longint'(w)) ? 0 : ((val << n) & wmask);
         end
         K_ROT: begin
            n   = cnt % longint'(w);
            res = ((val << n) | (val >> (longint'(w) - n))) & wmask;
         end
         default: begin
            n   = (64'd0 - cnt) % longint'(2 * w);
            res = (n >= longint'(w)) ? 0 : (val >> n);
         end
      endcase
      return 32'(res);
   endfunction

   function automatic rec_t ref_capture(input logic [0:10] o, input logic [2:0] f,
                                        input logic [0:6] a, input logic [0:127] x,
                                        input logic [0:127] y, input logic [0:17] im,
                                        input logic w_en);
      rec_t        r;
      int          kind, w;
      logic [31:0] c, res;
      r = '0;
      op_info(f, o, kind, w);
      if (f == 3'd0 && o == 11'd0) return r;
      r.addr = a;
      if (kind < 0) begin
         r.err = 1'b1;
         return r;
      end
      r.wr = w_en;
      if (w == 16) begin
         for (int i = 0; i < 8; i++) begin
            c   = (f == 3'd1) ? 32'(im[11:17]) : 32'(y[i*16 +: 16]);
            res = ref_lane(kind, 16, 32'(x[i*16 +: 16]), c);
            r.val[i*16 +: 16] = res[15:0];
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            c   = (f == 3'd1) ? 32'(im[11:17]) : y[i*32 +: 32];
            res = ref_lane(kind, 32, x[i*32 +: 32], c);
            r.val[i*32 +: 32] = res;
         end
      end
      return r;
   endfunction

   // Stage k holds whatever was captured k edges ago, unless killed since.
   function automatic rec_t exp_stage(input int k);
      int e;
      e = t - k;
      if (e < 0 || e <= last_kill) return '0;
      return hist[e];
   endfunction

   task automatic check_all();
      rec_t e;
      e = exp_stage(3);
      check("wb_L4", 256'({rt_wb4, rt_addr_wb4, reg_write_wb4, err_wb4}), 256'(e));
      e = exp_stage(1);
      check("wb_L2", 256'({rt_wb2, rt_addr_wb2, reg_write_wb2, err_wb2}), 256'(e));
      e = exp_stage(7);
      check("wb_L8", 256'({rt_wb8, rt_addr_wb8, reg_write_wb8, err_wb8}), 256'(e));
      for (int k = 0; k < 4; k++) begin
         e = exp_stage(k);
         check($sformatf("fwd_L4[%0d]", k), 256'({fwd_rt4[k], fwd_addr4[k], fwd_wr4[k]}),
               256'({e.val, e.addr, e.wr}));
      end
      for (int k = 0; k < 2; k++)
         check($sformatf("fwd_off_L2[%0d]", k), 256'({fwd_rt2[k], fwd_addr2[k], fwd_wr2[k]}), 256'(0));
      for (int k = 0; k < 8; k++) begin
         e = exp_stage(k);
         check($sformatf("fwd_L8[%0d]", k), 256'({fwd_rt8[k], fwd_addr8[k], fwd_wr8[k]}),
               256'({e.val, e.addr, e.wr}));
      end
   endtask

   // Advance one edge, record what the spec says was captured, then check #1 later.
   task automatic tick();
      @(posedge clk);
      t++;
      if (t >= MAXC) begin
         $display("FAIL cycle_budget: edge %0d exceeds model capacity %0d", t, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      if (!reset || flush) begin
         hist[t]   = '0;
         last_kill = t;
      end else begin
         hist[t] = ref_capture(op, format, rt_addr, ra, rb, imm, reg_write);
      end
      #1;
      check_all();
   endtask

   task automatic drive(input logic [0:10] o, input logic [2:0] f, input logic [0:6] a,
                        input logic [0:127] x, input logic [0:127] y, input logic [0:17] im,
                        input logic w_en);
      op = o; format = f; rt_addr = a; ra = x; rb = y; imm = im; reg_write = w_en;
   endtask

   task automatic drive_nop();
      drive(11'd0, 3'd0, 7'd0, '0, '0, '0, 1'b0);
   endtask

   task automatic drive_random();
      logic [0:10] known_op [10];
      logic [2:0]  known_fmt [10];
      int          sel;
      logic [0:127] x, y;
      known_op  = '{11'b00001011111, 11'b00001011011, 11'b00001011100, 11'b00001011000,
                    11'b00001011101, 11'b00001011001, 11'b00001111111, 11'b00001111011,
                    11'b00001111100, 11'b00001111000};
      known_fmt = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1};
      x = {$urandom, $urandom, $urandom, $urandom};
      y = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 0)
         for (int i = 0; i < 8; i++) y[i*16 +: 16] = 16'($urandom_range(0, 40));
      sel = $urandom_range(0, 13);
      if (sel < 10)
         drive(known_op[sel], known_fmt[sel], 7'($urandom), x, y, 18'($urandom), 1'($urandom));
      else if (sel == 10)
         drive_nop();
      else if (sel == 11)
         drive(11'($urandom), 3'($urandom_range(0, 1)), 7'($urandom), x, y, 18'($urandom), 1'($urandom));
      else if (sel == 12)
         drive(known_op[$urandom_range(0, 9)], 3'($urandom_range(2, 7)), 7'($urandom), x, y,
               18'($urandom), 1'($urandom));
      else
         drive(11'b00001011110, 3'd0, 7'($urandom), x, y, 18'($urandom), 1'b1);
   endtask

   initial begin
      vec_t vecs [5];
      int   old4, i3_4, old8, i3_8, i0_2, mid_2, lat2, lat8;

      vecs[0] = '{"shlh_counts", 11'b00001011111, 3'd0, {8{16'h0001}},
                  {16'd0, 16'd1, 16'd15, 16'd16, 16'd17, 16'd31, 16'd32, 16'd33}, 18'd0,
                  {16'h0001, 16'h0002, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0002},
                  1'b1, 1'b0};
      vecs[1] = '{"rot_word0", 11'b00001011000, 3'd0, {32'h80000001, 96'h0},
                  {32'd1, 96'h0}, 18'd0, {32'h00000003, 96'h0}, 1'b1, 1'b0};
      vecs[2] = '{"rothm_neg1", 11'b00001011101, 3'd0, {8{16'h8000}},
                  {8{16'hFFFF}}, 18'd0, {8{16'h4000}}, 1'b1, 1'b0};
      vecs[3] = '{"shli_imm4", 11'b00001111011, 3'd1, {8{16'h1111}},
                  {4{32'd31}}, 18'd4, {4{32'h11111110}}, 1'b1, 1'b0};
      vecs[4] = '{"unknown_op", 11'b00001011110, 3'd0, {4{32'hDEADBEEF}},
                  {4{32'd3}}, 18'd0, 128'h0, 1'b0, 1'b1};

      // Reset for two edges; every output must read zero.
      reset = 1'b0;
      flush = 1'b0;
      drive(11'b00001011111, 3'd0, 7'd5, {8{16'h1234}}, '0, '0, 1'b1);
      tick();
      tick();
      check("reset_L4", 256'({rt_wb4, rt_addr_wb4, reg_write_wb4, err_wb4}), 256'(0));
      check("reset_L8", 256'({rt_wb8, rt_addr_wb8, reg_write_wb8, err_wb8}), 256'(0));
      reset = 1'b1;

      // Table vectors, each observed at the LATENCY=4 writeback exactly 4 edges later.
      for (int i = 0; i < 5; i++) begin
         drive(vecs[i].op, vecs[i].fmt, 7'(i + 10), vecs[i].ra, vecs[i].rb, vecs[i].imm, 1'b1);
         tick();
         drive_nop();
         for (int j = 1; j < 4; j++) tick();
         check({vecs[i].name, "_val"},  256'(rt_wb4), 256'(vecs[i].exp_val));
         check({vecs[i].name, "_wr"},   256'(reg_write_wb4), 256'(vecs[i].exp_wr));
         check({vecs[i].name, "_err"},  256'(err_wb4), 256'(vecs[i].exp_err));
         check({vecs[i].name, "_addr"}, 256'(rt_addr_wb4), 256'(i + 10));
      end

      // Four back-to-back writers (addr 40..43), flush with the third one.
      old4 = 0; i3_4 = 0; old8 = 0; i3_8 = 0; i0_2 = 0; mid_2 = 0;
      for (int c = 0; c < 16; c++) begin
         if (c < 4) drive(11'b00001011011, 3'd0, 7'(40 + c), {4{32'h0000F00F}}, {4{32'd4}}, '0, 1'b1);
         else       drive_nop();
         flush = (c == 2);
         tick();
         flush = 1'b0;
         if (c == 2)
            check("flush_clears_L4", 256'({rt_wb4, rt_addr_wb4, reg_write_wb4, err_wb4}), 256'(0));
         if (reg_write_wb4 && rt_addr_wb4 inside {7'd40, 7'd41, 7'd42}) old4++;
         if (reg_write_wb4 && rt_addr_wb4 == 7'd43) i3_4++;
         if (reg_write_wb8 && rt_addr_wb8 inside {7'd40, 7'd41, 7'd42}) old8++;
         if (reg_write_wb8 && rt_addr_wb8 == 7'd43) i3_8++;
         if (reg_write_wb2 && rt_addr_wb2 == 7'd40) i0_2++;
         if (reg_write_wb2 && rt_addr_wb2 inside {7'd41, 7'd42}) mid_2++;
      end
      check("flush_killed_L4", 256'(old4), 256'(0));
      check("flush_after_L4",  256'(i3_4), 256'(1));
      check("flush_killed_L8", 256'(old8), 256'(0));
      check("flush_after_L8",  256'(i3_8), 256'(1));
      check("flush_retired_L2", 256'(i0_2), 256'(1));
      check("flush_killed_L2", 256'(mid_2), 256'(0));

      // One-cycle reset mid-stream, then time the next instruction at L=2 and L=8.
      for (int c = 0; c < 5; c++) begin
         drive(11'b00001011100, 3'd0, 7'(60 + c), {8{16'h00FF}}, {8{16'd3}}, '0, 1'b1);
         tick();
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("midreset_L2", 256'({rt_wb2, rt_addr_wb2, reg_write_wb2, err_wb2}), 256'(0));
      check("midreset_L4", 256'({rt_wb4, rt_addr_wb4, reg_write_wb4, err_wb4}), 256'(0));
      check("midreset_L8", 256'({rt_wb8, rt_addr_wb8, reg_write_wb8, err_wb8}), 256'(0));
      drive(11'b00001011000, 3'd0, 7'd77, {4{32'h80000001}}, {4{32'd1}}, '0, 1'b1);
      tick();
      drive_nop();
      lat2 = -1;
      lat8 = -1;
      for (int n = 1; n <= 12; n++) begin
         if (n > 1) tick();
         if (lat2 < 0 && reg_write_wb2 && rt_addr_wb2 == 7'd77) lat2 = n;
         if (lat8 < 0 && reg_write_wb8 && rt_addr_wb8 == 7'd77) lat8 = n;
      end
      check("latency_L2", 256'(lat2), 256'(2));
      check("latency_L8", 256'(lat8), 256'(8));

      // Randomized traffic with occasional flush and reset.
      for (int c = 0; c < 1200; c++) begin
         drive_random();
         flush = ($urandom_range(0, 99) < 3);
         reset = ($urandom_range(0, 99) >= 2);
         tick();
      end
      flush = 1'b0;
      reset = 1'b1;
      drive_nop();
      for (int c = 0; c < 10; c++) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/simple_fixed_shift.md
SIMPLE_FIXED_SHIFT -- requirements
Module: simple_fixed_shift

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning number of rising edges from operand capture to rt_wb (legal range 2..8).
REQ-002 SHALL have parameter FWD_EN, default 1, meaning in-flight stage contents are exposed on fwd_* ports (0 ties fwd_* to zero).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port op  input  [0:10]  decoded opcode, truncated by format.
REQ-006 SHALL have port format  input  [2:0]  0 = RR, 1 = RI7; others treated as unknown.
REQ-007 SHALL have port rt_addr  input  [0:6]  destination register.
REQ-008 SHALL have port ra, rb  input  [0:127] each  source operands.
REQ-009 SHALL have port imm  input  [0:17]  immediate; RI7 uses imm[11:17].
REQ-010 SHALL have port reg_write  input  1  instruction writes the register table.
REQ-011 SHALL have port flush  input  1  kill all in-flight instructions.
REQ-012 SHALL have ports rt_wb [0:127], rt_addr_wb [0:6], reg_write_wb 1, err_wb 1  outputs  writeback result, destination, write enable, unknown-op flag.
REQ-013 SHALL have ports fwd_rt [LATENCY][0:127], fwd_addr [LATENCY][0:6], fwd_wr [LATENCY]  outputs  per-stage bypass data, index 0 = youngest.

Function
REQ-014 SHALL compute the result in the capture cycle and move it through LATENCY staging registers; rt_wb/rt_addr_wb/reg_write_wb/err_wb SHALL be combinational copies of the last stage.
REQ-015 SHALL treat format 0 with op 0 as nop: captured stage value, address, reg_write and err all 0.
REQ-016 SHALL implement RR ops per halfword (8 lanes) or word (4 lanes), count taken from the matching rb lane: shlh 00001011111 (count = rb&0x1F, result 0 if count>=16), shl 00001011011 (rb&0x3F, 0 if >=32), roth 00001011100 (rotate left rb&0x0F), rot 00001011000 (rb&0x1F), rothm 00001011101 (logical right by (0-rb)&0x1F, 0 if >=16), rotm 00001011001 (logical right by (0-rb)&0x3F, 0 if >=32).
REQ-017 SHALL implement RI7 ops shlhi 00001111111, shli 00001111011, rothi 00001111100, roti 00001111000 identically to their RR counterparts, using imm[11:17] as the count for every lane.
REQ-018 SHALL, for any unknown format/op, capture value 0, reg_write 0, the presented rt_addr, and err 1.
REQ-019 SHALL, on flush=1 at an edge, clear value, address, reg_write and err of every staging register, and SHALL NOT capture the instruction presented that cycle.
REQ-020 SHALL leave the writeback presented during the flush cycle visible and unaltered (it is already committed).
REQ-021 SHALL accept one instruction per cycle with no stalls; back-to-back instructions to the same rt_addr SHALL each retire independently in order.
REQ-022 SHALL drive fwd_wr[k] = 1 only when stage k holds a live instruction with reg_write = 1.

Reset
REQ-023 SHALL, while reset = 0 at a rising edge, clear every staging register (value, address, reg_write, err) to 0; all outputs read 0 the following cycle.
REQ-024 SHALL give reset priority over flush and over input capture; instructions presented during reset are discarded.

Structure
REQ-025 SHALL place opcode constants, the format enum (RR, RI7) and lane-count constants in a shared package spu_pkg.
REQ-026 SHALL implement lane arithmetic in one sub-module spu_shift_lane, parameterised by lane width (16/32), instantiated per lane.

Verification
REQ-027 shlh, ra lanes = 16'h0001, rb lanes = 0,1,15,16,17,31,32,33 -> rt_wb lanes 0001,0002,8000,0,0,0,0001,0002 exactly LATENCY cycles later, reg_write_wb = 1.
REQ-028 rot, ra word0 = 32'h80000001, rb word0 = 1 -> word0 = 32'h00000003; rothm ra hw = 16'h8000, rb hw = 16'hFFFF (count 1) -> 16'h4000.
REQ-029 shli with imm[11:17] = 7'd4, ra all 16'h1111 words -> every word 32'h11111110.
REQ-030 Four back-to-back instructions, flush at cycle 2 -> only instructions already at the last stage retire; the rest never assert reg_write_wb.
REQ-031 Unknown op 00001011110 format 0 -> err_wb = 1, reg_write_wb = 0, rt_wb = 0 after LATENCY cycles.
REQ-032 reset = 0 for one cycle mid-stream at LATENCY = 2 and 8 -> all outputs 0 next cycle; next valid instruction retires after exactly LATENCY cycles.
